// File: rtl/poly_mod_mult_pkg.sv
// Shared types and helpers for the poly_mod_mult reduction path.
package poly_mod_mult_pkg;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/tree_adder.sv
// Registered N-input adder: sums NUM_IN words, result one cycle later.
// Output grows by $clog2(NUM_IN) bits so the sum can never wrap.
module tree_adder #(
  parameter  int NUM_IN   = 4,
  parameter  int IN_BITS  = 64,
  localparam int OUT_BITS = IN_BITS + $clog2(NUM_IN)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_IN-1:0][IN_BITS-1:0]   i_dat,
  output logic [OUT_BITS-1:0]              o_dat
);

  logic [OUT_BITS-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sum = sum + OUT_BITS'(i_dat[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dat <= '0;
    end else begin
      o_dat <= sum;
    end
  end

endmodule

// File: rtl/tree_adder_seq.sv
// Time-multiplexed sum: feeds CHUNK words per cycle through one tree_adder and accumulates.
// Latency NUM_CHUNKS+2 from accept to o_val; one transaction in flight, result held until i_rdy.
module tree_adder_seq
  import poly_mod_mult_pkg::*;
#(
  parameter  int NUM_IN   = 16,
  parameter  int IN_BITS  = 64,
  parameter  int CHUNK    = 4,
  localparam int OUT_BITS = IN_BITS + $clog2(NUM_IN)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_IN-1:0][IN_BITS-1:0]   i_dat,
  input  logic                             i_val,
  output logic                             o_rdy,
  output logic [OUT_BITS-1:0]              o_dat,
  output logic                             o_val,
  input  logic                             i_rdy,
  output logic                             o_busy
);

  localparam int NUM_CHUNKS = ceil_div(NUM_IN, CHUNK);
  localparam int SUM_BITS   = IN_BITS + $clog2(CHUNK);
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int IDX_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt;
  logic [NUM_IN-1:0][IN_BITS-1:0]  ops;
  logic [CHUNK-1:0][IN_BITS-1:0]   lanes;
  logic [SUM_BITS-1:0]             chunk_sum;
  logic [OUT_BITS-1:0]             acc;
  logic                            issue_vld;
  logic                            accept;
  logic                            last_chunk;

  assign accept     = (state == IDLE) && i_val;
  assign last_chunk = (cnt == CNT_W'(NUM_CHUNKS - 1));
  assign o_dat      = acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_rdy     = 1'b0;
    o_val     = 1'b0;
    o_busy    = 1'b1;
    case (state)
      IDLE: begin
        o_rdy  = 1'b1;
        o_busy = 1'b0;
        if (i_val) state_nxt = FEED;
      end
      FEED:  if (last_chunk) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
      DONE: begin
        o_val = 1'b1;
        if (i_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are only consumed after accept, so they need no reset.
  always_ff @(posedge i_clk) begin
    if (accept) ops <= i_dat;
  end

  // Lanes past the end of the operand vector read as zero so the last chunk can be partial.
  always_comb begin
    lanes = '0;
    for (int l = 0; l < CHUNK; l++) begin
      if (int'(cnt) * CHUNK + l < NUM_IN) begin
        lanes[l] = ops[IDX_W'(int'(cnt) * CHUNK + l)];
      end
    end
  end

  tree_adder #(
    .NUM_IN  (CHUNK),
    .IN_BITS (IN_BITS)
  ) u_tree_adder (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_dat   (lanes),
    .o_dat   (chunk_sum)
  );

  // issue_vld tracks the adder's one-cycle latency; accumulation trails issue by one edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      issue_vld <= 1'b0;
    end else begin
      issue_vld <= (state == FEED);
      if (accept) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        if (state == FEED) cnt <= cnt + 1'b1;
        if (issue_vld)     acc <= acc + OUT_BITS'(chunk_sum);
      end
    end
  end

endmodule
